gate_unit: RTL and testbench
============================

GATE_UNIT -- requirements
Module: gate_unit

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits, legal values 1 to 64.
REQ-002 Parameter CNT_W, default 16: width of the transaction counter.
REQ-003 clk  input  1: the single clock; all state updates on the rising edge.
REQ-004 rst  input  1: reset, synchronous and active-high.
REQ-005 in_valid  input  1: operand beat offered.
REQ-006 in_ready  output  1: unit accepts an operand beat this cycle.
REQ-007 a  input  WIDTH: operand A.
REQ-008 b  input  WIDTH: operand B.
REQ-009 op  input  3: operation select.
REQ-010 chain  input  1: replace B with the current y register value.
REQ-011 out_valid  output  1: result held on y.
REQ-012 out_ready  input  1: consumer takes the result.
REQ-013 y  output  WIDTH: registered result.
REQ-014 zero  output  1: registered flag, y == 0.
REQ-015 parity  output  1: registered flag, XOR-reduction of y.
REQ-016 txn_count  output  CNT_W: number of completed output handshakes, modulo 2^CNT_W.

Function
REQ-017 Op encoding, bitwise over WIDTH: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XNOR, 5 NOT A (B ignored), 6 XOR, 7 PASS A (B ignored).
REQ-018 Accept: an input beat transfers when in_valid and in_ready are both high in the same cycle.
REQ-019 Output transfer: a result transfers when out_valid and out_ready are both high in the same cycle.
REQ-020 in_ready = !out_valid || out_ready; this is combinational and has no dependence on in_valid.
REQ-021 Latency: exactly 1 cycle. y, zero and parity load on the accept edge, and out_valid is high from the following cycle.
REQ-022 Effective B = chain ? y (register value before the accept edge) : b. Chain also applies after y has been consumed or after reset (y = 0).
REQ-023 Stall: while out_valid is high and out_ready is low, y, zero, parity and out_valid stay unchanged and no beat is accepted.
REQ-024 Simultaneous output transfer and accept: out_valid stays 1, y loads the new result, and there is no bubble.
REQ-025 Output transfer with no accept: out_valid clears; y, zero and parity keep their values.
REQ-026 zero and parity are computed from the new result and registered together with y; they are never combinational from y.
REQ-027 txn_count increments by 1 on each output transfer and wraps from 2^CNT_W-1 to 0 with no flag.
REQ-028 Outputs never contain X after the first reset, for any op value including all 8 encodings.

Reset
REQ-029 While rst is high at a rising edge, the unit sets: out_valid=0, y=0, zero=1, parity=0, txn_count=0.
REQ-030 rst has priority over any simultaneous accept or output transfer; a pending result is discarded.
REQ-031 in_ready is 1 in the first cycle after reset is released.

Structure
REQ-032 A shared package gate_pkg holds the 3-bit op typedef/enum, the op constants 0-7 and the default WIDTH.
REQ-033 One combinational sub-module, gate_core (a, b_eff, op -> result), is instantiated once; the handshake, registers, flags and counter stay in gate_unit.

Verification
REQ-034 The bench applies WIDTH=8, a=F0, b=CC, each op 0-7 in turn with out_ready=1, and checks y one cycle later = C0, FC, 3F, 03, C3, 0F, 3C, F0.
REQ-035 The bench holds out_ready=0 after one accept (y=C0) and offers a=FF for 3 cycles; in_ready must be 0, y must stay C0 and txn_count must stay 0. The bench then raises out_ready, after which y=FF must follow with no bubble.
REQ-036 Chain: the bench issues XOR a=0F b=00 (y=0F), then XOR chain=1 a=FF; y must be F0, zero=0, parity=0.
REQ-037 Flags: AND a=AA b=55 must give y=00, zero=1, parity=0; PASS a=07 must give y=07, zero=0, parity=1.
REQ-038 Reset mid-stall: with out_valid=1 and out_ready=0, the bench pulses rst for 1 cycle. The next cycle must show out_valid=0, y=00, zero=1, txn_count=0 and in_ready=1.
REQ-039 With CNT_W=2, the bench performs 5 back-to-back transfers and txn_count must read 1.

Source files
------------

// File: rtl/gate_pkg.sv
// rtl/gate_pkg.sv - shared op encoding and default operand width for the gate unit
package gate_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NAND = 3'd2,
    OP_NOR  = 3'd3,
    OP_XNOR = 3'd4,
    OP_NOTA = 3'd5,
    OP_XOR  = 3'd6,
    OP_PASS = 3'd7
  } op_e;

endpackage

// File: rtl/gate_core.sv
// rtl/gate_core.sv - combinational bitwise operator selected by op
module gate_core
  import gate_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b_eff,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = '0;
    case (op_e'(op))
      OP_AND:  result = a & b_eff;
      OP_OR:   result = a | b_eff;
      OP_NAND: result = ~(a & b_eff);
      OP_NOR:  result = ~(a | b_eff);
      OP_XNOR: result = ~(a ^ b_eff);
      OP_NOTA: result = ~a;
      OP_XOR:  result = a ^ b_eff;
      OP_PASS: result = a;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/gate_unit.sv
// rtl/gate_unit.sv - one-deep registered gate operator with valid/ready handshake,
// result flags and a completed-transfer counter
module gate_unit
  import gate_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             chain,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             parity,
  output logic [CNT_W-1:0] txn_count
);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_y;
  logic             r_zero;
  logic             r_parity;
  logic [CNT_W-1:0] r_txn_count;

  logic             w_accept;
  logic             w_out_xfer;
  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH-1:0] w_result;

  assign in_ready   = !r_out_valid || out_ready;
  assign w_accept   = in_valid && in_ready;
  assign w_out_xfer = r_out_valid && out_ready;
  // Chaining feeds back the held register, even when it has already been consumed.
  assign w_b_eff    = chain ? r_y : b;

  gate_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a      (a),
    .b_eff  (w_b_eff),
    .op     (op),
    .result (w_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_y         <= '0;
      r_zero      <= 1'b1;
      r_parity    <= 1'b0;
      r_txn_count <= '0;
    end else begin
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_y         <= w_result;
        r_zero      <= (w_result == '0);
        r_parity    <= ^w_result;
      end else if (w_out_xfer) begin
        r_out_valid <= 1'b0;
      end
      if (w_out_xfer) begin
        r_txn_count <= r_txn_count + CNT_W'(1);
      end
    end
  end

  assign out_valid = r_out_valid;
  assign y         = r_y;
  assign zero      = r_zero;
  assign parity    = r_parity;
  assign txn_count = r_txn_count;

endmodule

// File: tb/tb_gate_unit.sv
// tb/tb_gate_unit.sv - directed bench for gate_unit with a result scoreboard and a CNT_W=2 twin
module tb_gate_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready, in_ready2;
  logic [7:0]  a, b;
  logic [2:0]  op;
  logic        chain;
  logic        out_valid, out_valid2;
  logic        out_ready;
  logic [7:0]  y, y2;
  logic        zero, zero2, parity, parity2;
  logic [15:0] txn_count;
  logic [1:0]  txn2;

  typedef struct {
    logic [7:0] y;
    logic       z;
    logic       p;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic       m_ov;
  logic [7:0] m_y;
  logic [15:0] m_cnt;

  always #5 clk = ~clk;

  gate_unit #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .chain(chain), .out_valid(out_valid),
    .out_ready(out_ready), .y(y), .zero(zero), .parity(parity),
    .txn_count(txn_count)
  );

  gate_unit #(.WIDTH(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .a(a), .b(b), .op(op), .chain(chain), .out_valid(out_valid2),
    .out_ready(out_ready), .y(y2), .zero(zero2), .parity(parity2),
    .txn_count(txn2)
  );

  function automatic logic [7:0] model(input logic [7:0] fa, input logic [7:0] fb,
                                       input logic [2:0] fop);
    case (fop)
      3'd0: return fa & fb;
      3'd1: return fa | fb;
      3'd2: return ~(fa & fb);
      3'd3: return ~(fa | fb);
      3'd4: return ~(fa ^ fb);
      3'd5: return ~fa;
      3'd6: return fa ^ fb;
      default: return fa;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input logic ordy);
    rst = 1'b1; in_valid = 1'b0; out_ready = ordy;
    @(posedge clk); #1;
    rst = 1'b0;
    m_ov = 1'b0; m_y = 8'h00; m_cnt = '0;
    sb.delete();
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_y", y, 8'h00);
    chk("rst_zero", zero, 1);
    chk("rst_parity", parity, 0);
    chk("rst_txn", txn_count, 0);
    chk("rst_txn2", txn2, 0);
    chk("rst_in_ready", in_ready, 1);
  endtask

  task automatic step(input string tag, input logic iv, input logic [7:0] ia, input logic [7:0] ib,
                      input logic [2:0] iop, input logic ich, input logic ordy);
    logic       exp_rdy, acc, xfer;
    logic [7:0] res;
    exp_t       e;
    in_valid = iv; a = ia; b = ib; op = iop; chain = ich; out_ready = ordy;
    #1;
    exp_rdy = !m_ov || ordy;
    chk({tag, "_in_ready"}, in_ready, exp_rdy);
    acc  = iv && exp_rdy;
    xfer = m_ov && ordy;
    if (acc) begin
      res = model(ia, ich ? m_y : ib, iop);
      e.y = res; e.z = (res == 8'h00); e.p = ^res;
      sb.push_back(e);
      m_y = res; m_ov = 1'b1;
    end else if (xfer) begin
      m_ov = 1'b0;
    end
    if (xfer) m_cnt = m_cnt + 16'd1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, "_out_valid"}, out_valid, m_ov);
    chk({tag, "_txn"}, txn_count, m_cnt);
    chk({tag, "_txn2"}, txn2, m_cnt[1:0]);
    chk({tag, "_known"}, $isunknown({in_ready, out_valid, y, zero, parity, txn_count}), 0);
    if (acc) begin
      if (sb.size() == 0) begin
        chk({tag, "_sb_empty"}, 1, 0);
      end else begin
        e = sb.pop_front();
        chk({tag, "_y"}, y, e.y);
        chk({tag, "_zero"}, zero, e.z);
        chk({tag, "_parity"}, parity, e.p);
      end
    end else begin
      chk({tag, "_y_hold"}, y, m_y);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0; chain = 1'b0; out_ready = 1'b0;
    m_ov = 1'b0; m_y = '0; m_cnt = '0;
    @(posedge clk); #1;
    do_reset(1'b1);

    step("and",  1, 8'hF0, 8'hCC, 3'd0, 0, 1);
    chk("and_lit", y, 8'hC0);
    step("or",   1, 8'hF0, 8'hCC, 3'd1, 0, 1);
    chk("or_lit", y, 8'hFC);
    step("nand", 1, 8'hF0, 8'hCC, 3'd2, 0, 1);
    chk("nand_lit", y, 8'h3F);
    step("nor",  1, 8'hF0, 8'hCC, 3'd3, 0, 1);
    chk("nor_lit", y, 8'h03);
    step("xnor", 1, 8'hF0, 8'hCC, 3'd4, 0, 1);
    chk("xnor_lit", y, 8'hC3);
    step("nota", 1, 8'hF0, 8'hCC, 3'd5, 0, 1);
    chk("nota_lit", y, 8'h0F);
    step("xor",  1, 8'hF0, 8'hCC, 3'd6, 0, 1);
    chk("xor_lit", y, 8'h3C);
    step("pass", 1, 8'hF0, 8'hCC, 3'd7, 0, 1);
    chk("pass_lit", y, 8'hF0);
    step("drain", 0, 8'h00, 8'h00, 3'd0, 0, 1);

    do_reset(1'b1);
    step("stall_acc", 1, 8'hF0, 8'hCC, 3'd0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step("stall", 1, 8'hFF, 8'h00, 3'd7, 0, 0);
      chk("stall_y_lit", y, 8'hC0);
      chk("stall_txn_lit", txn_count, 0);
    end
    step("release", 1, 8'hFF, 8'h00, 3'd7, 0, 1);
    chk("release_y_lit", y, 8'hFF);
    chk("release_ov_lit", out_valid, 1);
    step("drain2", 0, 8'h00, 8'h00, 3'd0, 0, 1);

    step("chain0", 1, 8'h0F, 8'h00, 3'd6, 0, 1);
    step("chain1", 1, 8'hFF, 8'h00, 3'd6, 1, 1);
    chk("chain_y_lit", y, 8'hF0);
    chk("chain_zero_lit", zero, 0);
    chk("chain_par_lit", parity, 0);

    step("flag_and", 1, 8'hAA, 8'h55, 3'd0, 0, 1);
    chk("flag_and_zero_lit", zero, 1);
    step("flag_pass", 1, 8'h07, 8'h00, 3'd7, 0, 1);
    chk("flag_pass_par_lit", parity, 1);
    step("drain3", 0, 8'h00, 8'h00, 3'd0, 0, 1);
    chk("drain_keep_y", y, 8'h07);

    step("pend", 1, 8'h12, 8'h34, 3'd1, 0, 0);
    step("pend_hold", 0, 8'h00, 8'h00, 3'd0, 0, 0);
    do_reset(1'b0);

    step("chain_rst", 1, 8'hAB, 8'h55, 3'd6, 1, 1);
    chk("chain_rst_lit", y, 8'hAB);

    do_reset(1'b1);
    for (int i = 0; i < 6; i++) begin
      step("b2b", 1, 8'(i), 8'h3C, 3'(i), 0, 1);
    end
    chk("cnt2_wrap_lit", txn2, 2'd1);
    chk("cnt16_lit", txn_count, 16'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
